n_serial_add: RTL and testbench

//  Bit-serial N-bit unsigned/two's-complement adder: the sequential counterpart
//  of the team's ripple-carry subtractor. Operands are latched on start, then

---
 rtl/n_serial_add.sv | 105 ++++++++++
 tb/tb_n_serial_add.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/n_serial_add.sv
// Bit-serial n-bit adder: operands are latched on start and summed LSB-first,
// one bit per clock, through a single full adder and a carry flip-flop.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module n_serial_add #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] y1,
  output logic         cout,
  output logic         ovf
);
  localparam int CNT_W = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [n-1:0]     sa;
  logic [n-1:0]     sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             co;

  full_adder u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (carry),
    .s   (s),
    .cout(co)
  );

  // On the last bit, the carry flip-flop still holds the carry into the MSB,
  // which is what the signed-overflow test needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      y1    <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            y1    <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          y1    <= {s, y1[n-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(n - 1)) begin
            cout  <= co;
            ovf   <= carry ^ co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_n_serial_add.sv
// Self-checking bench for n_serial_add: a scoreboard of expected sums is
// popped by an independent monitor whenever done pulses.

module tb_n_serial_add;
  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] y;
    logic         c;
    logic         o;
  } result_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] y1;
  logic         cout;
  logic         ovf;

  int      checks = 0;
  int      failures = 0;
  result_t sb_q[$];
  result_t last_exp;
  logic    prev_done = 1'b0;

  n_serial_add #(.n(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y1   (y1),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer addition; signed overflow when both
  // operands share a sign and the result does not.
  function automatic result_t model(input logic [N-1:0] x, input logic [N-1:0] z);
    logic [N:0] sum;
    result_t r;
    sum = {1'b0, x} + {1'b0, z};
    r.y = sum[N-1:0];
    r.c = sum[N];
    r.o = (x[N-1] == z[N-1]) && (r.y[N-1] != x[N-1]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending sum at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          checkOutput("y1", int'(y1), int'(e.y));
          checkOutput("cout", int'(cout), int'(e.c));
          checkOutput("ovf", int'(ovf), int'(e.o));
        end
      end
      if (prev_done === 1'b1) checkOutput("done_width", int'(done), 0);
      prev_done = done;
    end
  end

  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) checkOutput("idle_timeout", guard, 0);
  endtask

  task automatic applyStimulus(input logic [N-1:0] ai, input logic [N-1:0] bi);
    int lat;
    int busy_cycles;
    waitIdle();
    a = ai;
    b = bi;
    start = 1'b1;
    last_exp = model(ai, bi);
    sb_q.push_back(last_exp);
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    lat = 1;
    busy_cycles = busy ? 1 : 0;
    checkOutput("busy_on_accept", int'(busy), 1);
    checkOutput("y1_cleared", int'(y1), 0);
    checkOutput("cout_cleared", int'(cout), 0);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
    end
    checkOutput("latency", lat, N + 1);
    checkOutput("busy_cycles", busy_cycles, N);
  endtask

  initial begin
    int busy_cycles;
    int guard;
    int dones;
    int period;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_y1", int'(y1), 0);
    checkOutput("rst_cout", int'(cout), 0);
    checkOutput("rst_ovf", int'(ovf), 0);

    // Directed corner cases
    applyStimulus(8'd130, 8'd123);
    applyStimulus(8'd200, 8'd100);
    applyStimulus(8'd127, 8'd1);
    applyStimulus(8'd255, 8'd1);
    applyStimulus(8'd128, 8'd128);
    applyStimulus(8'd0, 8'd0);

    // Randomised operands with idle gaps; results must hold between requests
    for (int i = 0; i < 25; i++) begin
      applyStimulus(N'($urandom), N'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput("y1_hold", int'(y1), int'(last_exp.y));
      checkOutput("cout_hold", int'(cout), int'(last_exp.c));
    end

    // start held high with operands changing every cycle
    waitIdle();
    start = 1'b1;
    a = 8'd77;
    b = 8'd201;
    sb_q.push_back(model(8'd77, 8'd201));
    busy_cycles = 0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (busy) busy_cycles++;
      a = N'($urandom);
      b = N'($urandom);
    end while (!done && guard < 40);
    checkOutput("held_busy_cycles", busy_cycles, N);
    @(negedge clk);
    checkOutput("start_ignored_in_done", int'(busy), 0);
    start = 1'b0;

    // Reset during the fourth RUN cycle aborts the sum
    waitIdle();
    a = 8'hA5;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_y1", int'(y1), 0);
    checkOutput("abort_cout", int'(cout), 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("abort_no_done", dones, 0);
    applyStimulus(8'd99, 8'd58);

    // Back-to-back with start held constantly: 1+2 then 3+4
    waitIdle();
    a = 8'd1;
    b = 8'd2;
    start = 1'b1;
    sb_q.push_back(model(8'd1, 8'd2));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 40);
    checkOutput("b2b_first_done", int'(done), 1);
    a = 8'd3;
    b = 8'd4;
    sb_q.push_back(model(8'd3, 8'd4));
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!done && period < 40);
    start = 1'b0;
    checkOutput("b2b_period", period, N + 2);

    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
